xor_led_debounce: RTL and testbench
===================================

XOR_LED_DEBOUNCE -- requirements
Module: xor_led_debounce

Interface
REQ-001 Parameter NUM_PAIRS, default 4: number of switch pairs; legal range 1..8.
REQ-002 Parameter DB_CYCLES, default 4: debounce stability length in clocks; legal range 1..255.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port sw, input, 2*NUM_PAIRS: raw, asynchronous switch inputs; pair i is sw[2i] (A) and sw[2i+1] (B).
REQ-006 Port mode, input, 1: raw, asynchronous; 0 selects XOR and 1 selects XNOR for the pair outputs.
REQ-007 Port clr, input, 1: synchronous, active-high; clears the sticky flag and the change counter.
REQ-008 Port led, output, NUM_PAIRS+2: bits [NUM_PAIRS-1:0] are the pair results, bit NUM_PAIRS is global parity, bit NUM_PAIRS+1 is the sticky change flag.
REQ-009 Port chg_cnt, output, 8: saturating count of change events.

Function
REQ-010 Every sw bit and mode SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Each sw bit SHALL have a debounce counter of width clog2(DB_CYCLES+1) and a stable register.
REQ-012 Debounce rule: when synced value == stable, the counter SHALL clear to 0; otherwise the counter SHALL increment.
REQ-013 Debounce update: when the counter reaches DB_CYCLES-1 while synced != stable, stable SHALL take the synced value and the counter SHALL clear to 0 on that edge.
REQ-014 A glitch shorter than DB_CYCLES synced cycles SHALL leave stable unchanged.
REQ-015 The synchronized mode SHALL NOT be debounced.
REQ-016 Pair result i SHALL equal stable A XOR stable B, inverted when the synced mode is 1.
REQ-017 Parity SHALL equal the XOR of all 2*NUM_PAIRS stable bits and SHALL be independent of mode.
REQ-018 Pair results and parity SHALL be registered into led, adding one clock of latency.
REQ-019 Latency: a clean sw change first sampled at edge 1 SHALL appear on led at edge DB_CYCLES+3 (edge 7 with the default).
REQ-020 Mode latency: a mode change first sampled at edge 1 SHALL appear on led at edge 3.
REQ-021 Change event: a cycle in which the next registered value of led[NUM_PAIRS:0] differs from its current value SHALL count as one event, regardless of how many bits differ.
REQ-022 On a change event, the sticky flag SHALL set and chg_cnt SHALL increment by 1.
REQ-023 chg_cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-024 When clr is high: sticky flag <= 0 and chg_cnt <= 0.
REQ-025 When clr coincides with a change event: sticky flag <= 1 and chg_cnt <= 1 (the event wins over the clear).
REQ-026 The design SHALL contain no combinational path from any input to any output.

Reset
REQ-027 While rst_n is low, all of the following SHALL be 0 immediately, without waiting for a clock edge: synchronizers, debounce counters, stable registers, led, and chg_cnt.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; after release, the debounce SHALL restart from 0.
REQ-029 On the first edges after release with mode held at 1, the XNOR outputs rising to 1 SHALL count as one change event.
REQ-030 Reset release SHALL be treated as synchronous to clk by the integrator; no internal reset synchronizer is required.

Verification
REQ-031 Defaults, reset released, sw=0x00, mode=0 -> led=0x00 and chg_cnt=0 indefinitely.
REQ-032 Set sw[0]=1 and hold -> led[0]=1 and led[4]=1 at edge 7, led[5]=1 from edge 8, chg_cnt=1.
REQ-033 Pulse sw[2] high for 3 clocks (DB_CYCLES=4) -> led unchanged and chg_cnt unchanged.
REQ-034 With sw=0x05, toggle mode 0->1 -> led[3:0] goes 0011 to 1100 after 2 edges, led[4]=0 unchanged, chg_cnt increments by 1.
REQ-035 Force 300 change events by toggling mode -> chg_cnt=255; then assert clr for 1 cycle with no event -> chg_cnt=0 and led[5]=0.
REQ-036 Assert rst_n low mid-debounce (counter at 2) -> led=0 asynchronously; after release, the held switch value needs the full DB_CYCLES+3 edges to reach led.

Source files
------------

// File: rtl/xor_led_debounce.sv
// xor_led_debounce
//   Debounced switch-pair XOR/XNOR indicator with a global parity LED,
//   a sticky "something changed" LED and a saturating change counter.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset (release assumed synchronous)
//   sw       : raw switches, pair i = {sw[2i+1] (B), sw[2i] (A)}
//   mode     : raw mode select, 0 = XOR, 1 = XNOR (synchronized, not debounced)
//   clr      : synchronous clear of the sticky flag and change counter
//   led      : [NUM_PAIRS-1:0] pair results, [NUM_PAIRS] parity,
//              [NUM_PAIRS+1] sticky change flag
//   chg_cnt  : saturating count of change events on led[NUM_PAIRS:0]
module xor_led_debounce #(
  parameter int NUM_PAIRS = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*NUM_PAIRS-1:0] sw,
  input  logic                   mode,
  input  logic                   clr,
  output logic [NUM_PAIRS+1:0]   led,
  output logic [7:0]             chg_cnt
);

  localparam int NB = 2 * NUM_PAIRS;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // Two-flop synchronizers for every raw input
  logic [NB-1:0] sw_meta_reg, sw_sync_reg;
  logic          mode_meta_reg, mode_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_reg   <= '0;
      sw_sync_reg   <= '0;
      mode_meta_reg <= 1'b0;
      mode_sync_reg <= 1'b0;
    end else begin
      sw_meta_reg   <= sw;
      sw_sync_reg   <= sw_meta_reg;
      mode_meta_reg <= mode;
      mode_sync_reg <= mode_meta_reg;
    end
  end

  // Per-bit debounce: the counter only runs while the synced value
  // disagrees with the accepted (stable) value; any agreement restarts it.
  logic [NB-1:0] stable;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_db
      logic [CW-1:0] cnt_reg;
      logic          stable_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else if (sw_sync_reg[gi] == stable_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          stable_reg <= sw_sync_reg[gi];
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign stable[gi] = stable_reg;
    end
  endgenerate

  // Pair results and parity, registered into led
  logic [NUM_PAIRS:0] led_next;
  logic [NUM_PAIRS:0] led_reg;
  logic               change_event;

  generate
    for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
      assign led_next[gi] = stable[2*gi] ^ stable[2*gi+1] ^ mode_sync_reg;
    end
  endgenerate

  // Parity covers the stable bits only, so it never depends on mode.
  assign led_next[NUM_PAIRS] = ^stable;
  assign change_event        = (led_next != led_reg);

  logic       sticky_reg;
  logic       sticky_led_reg;
  logic [7:0] chg_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg        <= '0;
      sticky_reg     <= 1'b0;
      sticky_led_reg <= 1'b0;
      chg_cnt_reg    <= '0;
    end else begin
      led_reg <= led_next;
      // The sticky flag reaches the LED one clock after the event edge.
      sticky_led_reg <= sticky_reg;
      if (change_event) begin
        // An event in the same cycle as clr wins: the count restarts at 1.
        sticky_reg <= 1'b1;
        if (clr)
          chg_cnt_reg <= 8'd1;
        else if (chg_cnt_reg != 8'hFF)
          chg_cnt_reg <= chg_cnt_reg + 8'd1;
      end else if (clr) begin
        sticky_reg  <= 1'b0;
        chg_cnt_reg <= '0;
      end
    end
  end

  assign led     = {sticky_led_reg, led_reg};
  assign chg_cnt = chg_cnt_reg;

endmodule

// File: tb/tb_xor_led_debounce.sv
// Testbench for xor_led_debounce (default parameters NUM_PAIRS=4, DB_CYCLES=4).
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_xor_led_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       mode;
  logic       clr;
  logic [5:0] led;
  logic [7:0] chg_cnt;

  int checks = 0;
  int errors = 0;

  xor_led_debounce #(.NUM_PAIRS(4), .DB_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .mode    (mode),
    .clr     (clr),
    .led     (led),
    .chg_cnt (chg_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw;
    logic       mode;
    logic       clr;
    int         hold;
    logic [5:0] exp_led;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  initial begin
    // Table: each row is held 'hold' cycles, then led/chg_cnt compared.
    // Starting state: sw=0x05 stable, mode=0, led=0x23, chg_cnt=1.
    vecs[0] = '{8'h05, 1'b0, 1'b0, 10, 6'h23, 8'd1};  // steady, no events
    vecs[1] = '{8'h05, 1'b1, 1'b0, 10, 6'h2C, 8'd2};  // XOR->XNOR, one event
    vecs[2] = '{8'h05, 1'b1, 1'b1,  3, 6'h0C, 8'd0};  // clr, no event
    vecs[3] = '{8'h05, 1'b1, 1'b0, 10, 6'h0C, 8'd0};  // steady after clear
    vecs[4] = '{8'h03, 1'b0, 1'b0, 10, 6'h20, 8'd2};  // mode event then sw event
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 10, 6'h20, 8'd2};  // sw change, led identical
    vecs[6] = '{8'h80, 1'b1, 1'b0, 10, 6'h37, 8'd4};  // two separate events
    vecs[7] = '{8'h00, 1'b1, 1'b0, 10, 6'h2F, 8'd5};
    vecs[8] = '{8'h00, 1'b0, 1'b0, 10, 6'h20, 8'd6};

    rst_n = 1'b0; sw = 8'h00; mode = 1'b0; clr = 1'b0;
    #1;
    check("reset_led", led, 6'h00);
    check("reset_cnt", chg_cnt, 0);
    step(3);
    rst_n = 1'b1;
    step(10);
    check("idle_led", led, 6'h00);
    check("idle_cnt", chg_cnt, 0);

    // Latency: sw[0] rises, first sampled at edge 1
    sw = 8'h01;
    step(6);
    check("lat_e6_led", led, 6'h00);
    step(1);
    check("lat_e7_led", led, 6'h11);
    check("lat_e7_cnt", chg_cnt, 1);
    step(1);
    check("lat_e8_led", led, 6'h31);

    // Glitch of 3 clocks on sw[2] is rejected
    sw = 8'h05;
    step(3);
    sw = 8'h01;
    step(10);
    check("glitch_led", led, 6'h31);
    check("glitch_cnt", chg_cnt, 1);

    // Reset mid-debounce (counter at 2 after edge 4)
    sw = 8'h05;
    step(4);
    rst_n = 1'b0;
    #1;
    check("rst_async_led", led, 6'h00);
    check("rst_async_cnt", chg_cnt, 0);
    step(2);
    rst_n = 1'b1;
    step(6);
    check("rst_e6_led", led, 6'h00);
    step(1);
    check("rst_e7_led", led, 6'h03);
    step(1);
    check("rst_e8_led", led, 6'h23);
    check("rst_e8_cnt", chg_cnt, 1);

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      sw = vecs[i].sw; mode = vecs[i].mode; clr = vecs[i].clr;
      step(vecs[i].hold);
      check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
      check($sformatf("vec%0d_cnt", i), chg_cnt, vecs[i].exp_cnt);
    end
    clr = 1'b0;

    // Saturation: 300 mode toggles, each one event
    for (int i = 0; i < 300; i++) begin
      mode = ~mode;
      step(3);
    end
    check("sat_cnt", chg_cnt, 255);
    check("sat_led", led, 6'h20);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(2);
    check("clr_cnt", chg_cnt, 0);
    check("clr_led", led, 6'h00);

    // clr in the same cycle as an event: event wins
    mode = 1'b1;
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_evt_cnt", chg_cnt, 1);
    step(1);
    check("clr_evt_led", led, 6'h2F);

    // Reset release with mode held at 1: XNOR outputs rising is one event
    rst_n = 1'b0;
    step(2);
    check("rst_m1_led", led, 6'h00);
    rst_n = 1'b1;
    step(2);
    check("rel_e2_led", led, 6'h00);
    step(1);
    check("rel_e3_led", led, 6'h0F);
    check("rel_e3_cnt", chg_cnt, 1);
    step(1);
    check("rel_e4_led", led, 6'h2F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
